// File: rtl/morse_pkg.sv
// Shared encodings for the Morse key front end: event types, entry modes and
// controller states.
package morse_pkg;

   typedef enum logic [1:0] {
      EV_DOT    = 2'b00,
      EV_DASH   = 2'b01,
      EV_COMMIT = 2'b10
   } ev_type_e;

   typedef enum logic {
      MODE_GAP   = 1'b0,
      MODE_PRESS = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_PRESS = 2'b01,
      ST_GAP   = 2'b10
   } state_e;

endpackage

// File: rtl/morse_key_ctrl_debounce.sv
// Two-flop synchronizer followed by a stability counter; key follows the
// synchronized input only after DEBOUNCE consecutive differing samples.
module morse_debounce #(
   parameter int DEBOUNCE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic key
);

   localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

   logic [1:0]      sync_q, sync_d;
   logic            key_q, key_d;
   logic [DB_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync_d = {sync_q[0], din};
      key_d  = key_q;
      cnt_d  = '0;
      // Any sample equal to key restarts the run count.
      if (sync_q[1] != key_q) begin
         if (cnt_q == DB_LAST) begin
            key_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + DB_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         key_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         key_q  <= key_d;
         cnt_q  <= cnt_d;
      end
   end

   assign key = key_q;

endmodule

// File: rtl/morse_key_ctrl.sv
// Times debounced key presses and gaps, classifies them into DOT/DASH/COMMIT
// events, tracks entry mode and letter length, and holds one outgoing event.
module morse_key_ctrl
   import morse_pkg::*;
#(
   parameter int DEBOUNCE = 4,
   parameter int DASH_MIN = 1500,
   parameter int LONG_MIN = 4500,
   parameter int REV_MIN  = 12000,
   parameter int GAP_MIN  = 4500,
   parameter int MAX_SYM  = 5,
   parameter int CNT_W    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
   output logic       ev_valid,
   output logic [1:0] ev_type,
   input  logic       ev_ready,
   output logic       mode,
   output logic [2:0] sym_cnt,
   output logic       err
);

   localparam logic [CNT_W-1:0] DASH_L = CNT_W'(DASH_MIN);
   localparam logic [CNT_W-1:0] LONG_L = CNT_W'(LONG_MIN);
   localparam logic [CNT_W-1:0] REV_L  = CNT_W'(REV_MIN);
   localparam logic [CNT_W-1:0] GAP_L  = CNT_W'(GAP_MIN);
   localparam logic [2:0]       MAX_L  = 3'(MAX_SYM);

   logic             key;
   logic             key_prev_q, key_prev_d;
   logic             rise, fall;
   logic [CNT_W-1:0] dur_q, dur_d;
   state_e           state_q, state_d;
   mode_e            mode_q, mode_d;
   logic [2:0]       sym_q, sym_d;
   logic             err_q, err_d;
   logic             ev_valid_q, ev_valid_d;
   ev_type_e         ev_type_q, ev_type_d;
   logic             req, can_load, gap_commit, commit_issued;
   ev_type_e         req_type;

   morse_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
      .clk (clk),
      .rst (rst),
      .din (din),
      .key (key)
   );

   assign rise = key & ~key_prev_q;
   assign fall = ~key & key_prev_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (rise) state_d = ST_PRESS;
         ST_GAP: begin
            if (rise)               state_d = ST_PRESS;
            else if (commit_issued) state_d = ST_IDLE;
         end
         ST_PRESS: if (fall) state_d = (sym_d != 3'd0) ? ST_GAP : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      key_prev_d = key;
      dur_d      = dur_q;
      if (rise || fall)      dur_d = CNT_W'(1);
      else if (dur_q != '1)  dur_d = dur_q + CNT_W'(1);

      mode_d   = mode_q;
      sym_d    = sym_q;
      err_d    = err_q;
      req      = 1'b0;
      req_type = EV_DOT;
      // A press starting on the same cycle the gap matures takes priority.
      gap_commit = (state_q == ST_GAP) && (mode_q == MODE_GAP) && (dur_q == GAP_L) && !rise;

      if (fall) begin
         if (dur_q < DASH_L) begin
            req = 1'b1;
         end else if (dur_q < LONG_L) begin
            req      = 1'b1;
            req_type = EV_DASH;
         end else if (mode_q == MODE_GAP) begin
            mode_d = MODE_PRESS;
            sym_d  = 3'd0;
         end else if (dur_q < REV_L) begin
            req      = 1'b1;
            req_type = EV_COMMIT;
         end else begin
            mode_d = MODE_GAP;
            sym_d  = 3'd0;
         end
      end else if (gap_commit) begin
         req      = 1'b1;
         req_type = EV_COMMIT;
      end

      if (req && (req_type != EV_COMMIT) && (sym_q >= MAX_L)) begin
         req   = 1'b0;
         err_d = 1'b1;
      end
      if (req && (req_type == EV_COMMIT) && (sym_q == 3'd0)) begin
         req = 1'b0;
      end

      can_load   = !ev_valid_q || ev_ready;
      ev_valid_d = ev_valid_q && !ev_ready;
      ev_type_d  = ev_type_q;
      if (req) begin
         if (can_load) begin
            ev_valid_d = 1'b1;
            ev_type_d  = req_type;
            sym_d      = (req_type == EV_COMMIT) ? 3'd0 : sym_q + 3'd1;
         end else begin
            err_d = 1'b1;
         end
      end
      commit_issued = req && can_load && (req_type == EV_COMMIT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_prev_q <= 1'b0;
         dur_q      <= '0;
         mode_q     <= MODE_GAP;
         sym_q      <= 3'd0;
         err_q      <= 1'b0;
         ev_valid_q <= 1'b0;
         ev_type_q  <= EV_DOT;
      end else begin
         key_prev_q <= key_prev_d;
         dur_q      <= dur_d;
         mode_q     <= mode_d;
         sym_q      <= sym_d;
         err_q      <= err_d;
         ev_valid_q <= ev_valid_d;
         ev_type_q  <= ev_type_d;
      end
   end

   always_comb begin
      ev_valid = ev_valid_q;
      ev_type  = ev_type_q;
      mode     = mode_q;
      sym_cnt  = sym_q;
      err      = err_q;
   end

endmodule
